multiplicador_sequencial_param: RTL

MULTIPLICADOR_SEQUENCIAL_PARAM -- requirements
Module: multiplicador_sequencial_param

---
 rtl/multiplicador_sequencial_param.sv | 138 +++++++++++++
 1 files changed

// File: rtl/multiplicador_sequencial_param.sv
// Sequential shift-add multiplier with unsigned/signed operand modes.
// A magnitude product is built over WIDTH shift-add steps. A final step then
// applies the sign, computes overflow, and either saturates or wraps the
// narrow result.
module multiplicador_sequencial_param #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicando,
  input  logic [WIDTH-1:0]     multiplicador,
  output logic [WIDTH-1:0]     produto,
  output logic [2*WIDTH-1:0]   produto_full,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;

  state_t          r_state;
  state_t          w_next;

  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_signed;

  logic             w_load;
  logic             w_step;
  logic             w_finish;
  logic [PW-1:0]    w_full;
  logic             w_ovf;

  // Magnitude of an operand. In signed mode the most negative value maps to
  // 2^(WIDTH-1), which still fits because the result is read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    if (sgn && v[WIDTH-1]) return (~v) + WIDTH'(1);
    return v;
  endfunction

  // The product fits in WIDTH bits when the dropped upper bits are pure
  // extension: zeros in unsigned mode, copies of the result MSB in signed mode.
  function automatic logic ovf_check(input logic [PW-1:0] full,
                                     input logic          sgn);
    if (sgn) return !((full[PW-1:WIDTH-1] == '0) || (full[PW-1:WIDTH-1] == '1));
    return full[PW-1:WIDTH] != '0;
  endfunction

  // Narrow result: clamp to the representable extreme on overflow when
  // saturation is enabled, otherwise keep the low WIDTH bits.
  function automatic logic [WIDTH-1:0] sat_value(input logic [PW-1:0] full,
                                                 input logic          sgn,
                                                 input logic          ovf);
    if ((SATURATE == 0) || !ovf) return full[WIDTH-1:0];
    if (!sgn) return '1;
    if (full[PW-1]) return {1'b1, {(WIDTH-1){1'b0}}};
    return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // Operands are accepted from IDLE, and from FIM for back-to-back operation.
  assign w_load   = start && ((r_state == IDLE) || (r_state == FIM));
  assign w_step   = (r_state == CALC) && (r_cnt != '0);
  assign w_finish = (r_state == CALC) && (r_cnt == '0);

  // A zero magnitude product is never negated, so no negative zero appears.
  assign w_full = (r_neg && (r_acc != '0)) ? ((~r_acc) + PW'(1)) : r_acc;
  assign w_ovf  = ovf_check(w_full, r_signed);

  assign busy = (r_state == CALC);
  assign done = (r_state == FIM);

  // State register. The asynchronous clear forces IDLE at once, so a
  // reset during CALC aborts the operation without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic. CALC holds for WIDTH steps plus one finishing cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (r_cnt == '0) w_next = FIM;
      FIM:     w_next = start ? CALC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Shift-add datapath. Each step is LSB-first on |B|, with |A| shifted left
  // into the full 2*WIDTH accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_signed <= 1'b0;
    end else if (w_load) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, magnitude(multiplicando, signed_mode)};
      r_mplier <= magnitude(multiplicador, signed_mode);
      r_cnt    <= CW'(WIDTH);
      r_neg    <= signed_mode && (multiplicando[WIDTH-1] ^ multiplicador[WIDTH-1]);
      r_signed <= signed_mode;
    end else if (w_step) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

  // Result registers. They change only on the transition into FIM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      produto      <= '0;
      produto_full <= '0;
      overflow     <= 1'b0;
    end else if (w_finish) begin
      produto      <= sat_value(w_full, r_signed, w_ovf);
      produto_full <= w_full;
      overflow     <= w_ovf;
    end
  end

endmodule
